// File: rtl/pair_index_generator.sv
// Pair-request producer: on a start request, draws six distinct 4-bit LED
// indices from a free-running 16-bit LFSR, latches them onto A..F together
// and announces the new set with a one-cycle done pulse.
module pair_index_generator #(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          MAX_TRIES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] C,
  output logic [3:0] D,
  output logic [3:0] E,
  output logic [3:0] F,
  output logic       done,
  output logic       busy
);

  // An all-zero LFSR would lock up, so a zero seed falls back to the default.
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [7:0]  TRY_LIMIT = 8'(MAX_TRIES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] lfsr;
  logic [15:0] mask;
  logic [2:0]  slot;
  logic [7:0]  tries;
  logic [3:0]  shadow [6];

  logic [3:0]  cand;
  logic        hit;
  logic [7:0]  tries_inc;
  logic        fallback;
  logic        accept;
  logic [3:0]  pick;

  // Fibonacci step: shift left, feedback from taps 15, 13, 12 and 10.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Lowest index whose mask bit is clear; at most five bits are ever set
  // when this is consulted, so a free index always exists.
  function automatic logic [3:0] lowest_unused(input logic [15:0] m);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (!m[i]) r = 4'(i);
    end
    return r;
  endfunction

  assign busy = (state != ST_IDLE);

  // Candidate evaluation and next-state selection.
  always_comb begin
    state_next = state;
    cand       = lfsr[3:0];
    hit        = mask[cand];
    tries_inc  = tries + 8'd1;
    fallback   = hit && (tries_inc == TRY_LIMIT);
    accept     = (state == ST_DRAW) && (!hit || fallback);
    pick       = hit ? lowest_unused(mask) : cand;
    case (state)
      ST_IDLE: if (enable) state_next = ST_DRAW;
      ST_DRAW: if (accept && (slot == 3'd5)) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // LFSR, used-index mask, slot pointer and rejection counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr  <= SEED_EFF;
      mask  <= 16'h0000;
      slot  <= 3'd0;
      tries <= 8'd0;
    end else begin
      lfsr <= lfsr_step(lfsr);
      case (state)
        ST_IDLE: begin
          if (enable) begin
            mask  <= 16'h0000;
            slot  <= 3'd0;
            tries <= 8'd0;
          end
        end
        ST_DRAW: begin
          if (accept) begin
            mask[pick] <= 1'b1;
            slot       <= slot + 3'd1;
            tries      <= 8'd0;
          end else begin
            tries <= tries_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // Shadow slots collect accepted picks; only A..F are architecturally visible.
  always_ff @(posedge clk) begin
    if (accept) shadow[slot] <= pick;
  end

  // Output latch: all six indices and the done pulse leave DONE on one edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      A    <= 4'd0;
      B    <= 4'd0;
      C    <= 4'd0;
      D    <= 4'd0;
      E    <= 4'd0;
      F    <= 4'd0;
      done <= 1'b0;
    end else begin
      done <= (state == ST_DONE);
      if (state == ST_DONE) begin
        A <= shadow[0];
        B <= shadow[1];
        C <= shadow[2];
        D <= shadow[3];
        E <= shadow[4];
        F <= shadow[5];
      end
    end
  end

endmodule

// File: tb/tb_pair_index_generator.sv
// Bench for pair_index_generator: two instances (MAX_TRIES=8 and 1) share
// clock and inputs; each is checked every cycle against a draw-level model.
module tb_pair_index_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       enable;
  logic [3:0] o8 [6];
  logic [3:0] o1 [6];
  logic       done8, busy8, done1, busy1;

  pair_index_generator #(.SEED(16'hACE1), .MAX_TRIES(8)) u8 (
    .clk(clk), .rst(rst), .enable(enable),
    .A(o8[0]), .B(o8[1]), .C(o8[2]), .D(o8[3]), .E(o8[4]), .F(o8[5]),
    .done(done8), .busy(busy8)
  );

  pair_index_generator #(.SEED(16'hACE1), .MAX_TRIES(1)) u1 (
    .clk(clk), .rst(rst), .enable(enable),
    .A(o1[0]), .B(o1[1]), .C(o1[2]), .D(o1[3]), .E(o1[4]), .F(o1[5]),
    .done(done1), .busy(busy1)
  );

  logic [23:0] act [2];
  logic        act_done [2];
  logic        act_busy [2];
  assign act[0] = {o8[5], o8[4], o8[3], o8[2], o8[1], o8[0]};
  assign act[1] = {o1[5], o1[4], o1[3], o1[2], o1[1], o1[0]};
  assign act_done[0] = done8;
  assign act_done[1] = done1;
  assign act_busy[0] = busy8;
  assign act_busy[1] = busy1;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [15:0] step(input logic [15:0] l);
    return (l << 1) | 16'(^(l & 16'hB400));
  endfunction

  function automatic int lowest_free(input logic [15:0] used);
    for (int i = 0; i < 16; i++) if (!used[i]) return i;
    return -1;
  endfunction

  // Runs one whole draw from the first DRAW-cycle LFSR value; returns the
  // six picks (slot k at bits 4k+3:4k) and the number of DRAW cycles spent.
  task automatic draw(input logic [15:0] l0, input int mt,
                      output logic [23:0] picks, output int ncyc);
    logic [15:0] l;
    logic [15:0] used;
    logic [3:0]  c;
    int          tries;
    int          got;
    l = l0; used = 16'h0; ncyc = 0; picks = 24'h0;
    for (int k = 0; k < 6; k++) begin
      tries = 0;
      got   = -1;
      while (got < 0) begin
        ncyc++;
        c = l[3:0];
        l = step(l);
        if (!used[c]) got = int'(c);
        else begin
          tries++;
          if (tries >= mt) got = lowest_free(used);
        end
      end
      used[got] = 1'b1;
      picks[4*k +: 4] = 4'(got);
    end
  endtask

  function automatic bit all_distinct(input logic [23:0] v);
    for (int i = 0; i < 6; i++)
      for (int j = i + 1; j < 6; j++)
        if (v[4*i +: 4] == v[4*j +: 4]) return 1'b0;
    return 1'b1;
  endfunction

  localparam int MT [2] = '{8, 1};
  string       nm [2] = '{"u8", "u1"};
  logic [15:0] mlfsr [2];
  int          rem [2];
  logic [23:0] pend [2];
  logic [23:0] expo [2];
  logic        expdone [2];
  logic        expbusy [2];

  // Model update on every active edge, from the inputs sampled at that edge.
  initial begin
    int n;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rst) begin
          mlfsr[i] = 16'hACE1; rem[i] = 0; expo[i] = 24'h0;
          expdone[i] = 1'b0; expbusy[i] = 1'b0;
        end else begin
          expdone[i] = 1'b0;
          if (rem[i] == 0) begin
            if (enable) begin
              draw(step(mlfsr[i]), MT[i], pend[i], n);
              rem[i] = n + 1;
              expbusy[i] = 1'b1;
            end
          end else begin
            rem[i]--;
            if (rem[i] == 0) begin
              expo[i] = pend[i]; expdone[i] = 1'b1; expbusy[i] = 1'b0;
            end
          end
          mlfsr[i] = step(mlfsr[i]);
        end
      end
    end
  end

  // ---------------- compare process ----------------
  logic        chk_on = 1'b0;
  int          dcount [2] = '{0, 0};
  int          bcnt [2]   = '{0, 0};
  logic [23:0] prev [2];
  logic [23:0] last_set [2];
  int          hist [16];

  initial begin
    for (int k = 0; k < 16; k++) hist[k] = 0;
    forever begin
      @(posedge clk);
      #2;
      if (chk_on) begin
        for (int i = 0; i < 2; i++) begin
          check({nm[i], "_outs"}, 32'(act[i]), 32'(expo[i]));
          check({nm[i], "_done"}, 32'(act_done[i]), 32'(expdone[i]));
          check({nm[i], "_busy"}, 32'(act_busy[i]), 32'(expbusy[i]));
          if (rst && !act_done[i])
            check({nm[i], "_stable"}, 32'(act[i] == prev[i]), 32'd1);
          if (act_busy[i]) bcnt[i]++;
          if (act_done[i]) begin
            dcount[i]++;
            last_set[i] = act[i];
            check({nm[i], "_distinct"}, 32'(all_distinct(act[i])), 32'd1);
            check({nm[i], "_latency"}, 32'(bcnt[i] <= 1 + 6 * MT[i] && bcnt[i] >= 7), 32'd1);
            if (i == 0) for (int k = 0; k < 6; k++) hist[act[0][4*k +: 4]]++;
          end
          if (!act_busy[i]) bcnt[i] = 0;
          prev[i] = act[i];
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_and_start(input int hold);
    rst = 1'b0; enable = 1'b0;
    tick(hold);
    rst = 1'b1;
    tick(50);
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
  endtask

  task automatic wait_done(input int idx, input int base, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (dcount[idx] > base) break;
      tick(1);
    end
  endtask

  initial begin
    logic [23:0] p;
    logic [23:0] t2set [2];
    int          n, d0, d1;
    rst = 1'b0; enable = 1'b0;

    // Model pins: hand-computed values.
    check("pin_step_ace1", 32'(step(16'hACE1)), 32'h59C3);
    check("pin_step_8000", 32'(step(16'h8000)), 32'h0001);
    check("pin_lowest_free", 32'(lowest_free(16'h0007)), 32'd3);
    draw(16'h0000, 1, p, n);
    check("pin_draw_mt1_picks", 32'(p), 32'h543210);
    check("pin_draw_mt1_cycles", 32'(n), 32'd6);
    draw(16'h0000, 8, p, n);
    check("pin_draw_mt8_picks", 32'(p), 32'h543210);
    check("pin_draw_mt8_cycles", 32'(n), 32'd41);

    // T1 reset
    tick(1);
    chk_on = 1'b1;
    tick(2);
    check("t1_reset_outs", 32'(act[0] | act[1]), 32'd0);
    check("t1_reset_done", 32'({done8, done1}), 32'd0);
    check("t1_reset_busy", 32'({busy8, busy1}), 32'd0);
    rst = 1'b1;
    tick(50);
    check("t1_idle_no_done", 32'(dcount[0] + dcount[1]), 32'd0);

    // T2 single draw
    reset_and_start(3);
    wait_done(0, 0, 60);
    tick(10);
    check("t2_done_u8", 32'(dcount[0]), 32'd1);
    check("t2_done_u1", 32'(dcount[1]), 32'd1);
    t2set[0] = last_set[0];
    t2set[1] = last_set[1];

    // T5 enable while busy is ignored
    d0 = dcount[0]; d1 = dcount[1];
    enable = 1'b1; tick(1); enable = 1'b0;
    tick(3);
    enable = 1'b1; tick(1); enable = 1'b0;
    tick(80);
    check("t5_one_done_u8", 32'(dcount[0] - d0), 32'd1);
    check("t5_one_done_u1", 32'(dcount[1] - d1), 32'd1);

    // T3/T4 soak with enable held high
    d0 = dcount[0]; d1 = dcount[1];
    enable = 1'b1;
    for (int k = 0; k < 20000; k++) begin
      if (dcount[0] - d0 >= 1000) break;
      tick(1);
    end
    enable = 1'b0;
    tick(60);
    check("t3_soak_count", 32'(dcount[0] - d0 >= 1000), 32'd1);
    check("t4_fallback_count", 32'(dcount[1] - d1 >= 200), 32'd1);
    for (int k = 0; k < 16; k++)
      check($sformatf("t3_hist_%0d", k), 32'(hist[k] > 0), 32'd1);

    // T6 reset during DRAW
    d0 = dcount[0];
    enable = 1'b1; tick(1); enable = 1'b0;
    tick(3);
    rst = 1'b0;
    @(posedge clk); #2;
    check("t6_busy", 32'({busy8, busy1}), 32'd0);
    check("t6_done", 32'({done8, done1}), 32'd0);
    check("t6_outs", 32'(act[0] | act[1]), 32'd0);
    tick(1);
    check("t6_no_done", 32'(dcount[0] - d0), 32'd0);
    d0 = dcount[0]; d1 = dcount[1];
    reset_and_start(1);
    wait_done(0, d0, 60);
    tick(10);
    check("t6_redo_count", 32'(dcount[0] - d0), 32'd1);
    check("t6_same_u8", 32'(last_set[0]), 32'(t2set[0]));
    check("t6_same_u1", 32'(last_set[1]), 32'(t2set[1]));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
